// File: rtl/ctrl_pkg.sv
// Shared definitions for the command scheduler: opcode bit positions, engine
// encodings, per-engine FSM states and the saturating counter helper.
package ctrl_pkg;

    localparam int DEFAULT_ADDRW   = 24;
    localparam int DEFAULT_OPCODEW = 2;

    localparam int OP_ENGINE_BIT = 0;
    localparam int OP_DIR_BIT    = 1;

    localparam logic ENG_AES = 1'b0;
    localparam logic ENG_SHA = 1'b1;

    localparam int STAT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } eng_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/engine_slot.sv
// One engine's IDLE/RUN controller with a single-entry holding slot in front of it.
// The payload is opaque here; the top decides which command fields it carries.
module engine_slot
    import ctrl_pkg::*;
#(
    parameter int PAYW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    input  logic [PAYW-1:0] cmd_payload,
    input  logic            done,
    output logic            start,
    output logic            busy,
    output logic            ready,
    output logic [PAYW-1:0] payload,
    output logic            done_run,
    output logic            drop
);

    eng_state_t      state, state_next;
    logic            slot_full, slot_full_next;
    logic [PAYW-1:0] slot_reg;
    logic            load_cmd, load_slot, store_slot;

    // A done with a full slot always wins the engine; a command arriving in
    // the same cycle is dropped even though the slot frees up.
    always_comb begin
        state_next     = state;
        slot_full_next = slot_full;
        load_cmd       = 1'b0;
        load_slot      = 1'b0;
        store_slot     = 1'b0;
        done_run       = (state == ST_RUN) && done;
        drop           = cmd_valid && slot_full;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    load_cmd   = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (done) begin
                    if (slot_full) begin
                        load_slot      = 1'b1;
                        slot_full_next = 1'b0;
                    end else if (cmd_valid) begin
                        load_cmd = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (cmd_valid && !slot_full) begin
                    store_slot     = 1'b1;
                    slot_full_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            slot_full <= 1'b0;
            slot_reg  <= '0;
            payload   <= '0;
            start     <= 1'b0;
        end else begin
            state     <= state_next;
            slot_full <= slot_full_next;
            start     <= load_cmd | load_slot;
            if (store_slot) begin
                slot_reg <= cmd_payload;
            end
            if (load_cmd) begin
                payload <= cmd_payload;
            end else if (load_slot) begin
                payload <= slot_reg;
            end
        end
    end

    assign busy  = (state == ST_RUN);
    assign ready = ~slot_full;

endmodule

// File: rtl/cmd_scheduler.sv
// Dispatches commands to the AES and SHA engines, arbitrates their shared bus
// and keeps drop/completion statistics (compiled in with CMD_SCHED_STATS_EN).
module cmd_scheduler
    import ctrl_pkg::*;
#(
    parameter int ADDRW   = DEFAULT_ADDRW,
    parameter int OPCODEW = DEFAULT_OPCODEW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_pulse,
    input  logic               cmd_en,
    input  logic [OPCODEW-1:0] cmd_opcode,
    input  logic [ADDRW-1:0]   cmd_key_addr,
    input  logic [ADDRW-1:0]   cmd_text_addr,
    input  logic [ADDRW-1:0]   cmd_dest_addr,
    output logic               aes_ready_out,
    output logic               sha_ready_out,
    output logic               aes_start,
    output logic               aes_decrypt,
    output logic [ADDRW-1:0]   aes_key_addr,
    output logic [ADDRW-1:0]   aes_text_addr,
    output logic [ADDRW-1:0]   aes_dest_addr,
    input  logic               aes_done,
    output logic               sha_start,
    output logic [ADDRW-1:0]   sha_text_addr,
    output logic [ADDRW-1:0]   sha_dest_addr,
    input  logic               sha_done,
    input  logic               aes_bus_req,
    input  logic               sha_bus_req,
    output logic               aes_bus_gnt,
    output logic               sha_bus_gnt,
    output logic               aes_busy,
    output logic               sha_busy,
    output logic               cmd_overflow,
    output logic [15:0]        stat_aes_cnt,
    output logic [15:0]        stat_sha_cnt,
    output logic [15:0]        stat_drop_cnt
);

    localparam int AES_PAYW = 3 * ADDRW + 1;
    localparam int SHA_PAYW = 2 * ADDRW;

    logic                cmd_accept, cmd_discard, aes_cmd, sha_cmd;
    logic [AES_PAYW-1:0] aes_cmd_pay, aes_pay;
    logic [SHA_PAYW-1:0] sha_cmd_pay, sha_pay;
    logic                aes_done_run, sha_done_run, aes_drop, sha_drop;
    logic                aes_gnt_next, sha_gnt_next, prio_sha;

    assign cmd_accept  = cmd_pulse & cmd_en;
    assign cmd_discard = cmd_pulse & ~cmd_en;
    assign aes_cmd     = cmd_accept & (cmd_opcode[OP_ENGINE_BIT] == ENG_AES);
    assign sha_cmd     = cmd_accept & (cmd_opcode[OP_ENGINE_BIT] == ENG_SHA);
    assign aes_cmd_pay = {cmd_opcode[OP_DIR_BIT], cmd_key_addr, cmd_text_addr, cmd_dest_addr};
    assign sha_cmd_pay = {cmd_text_addr, cmd_dest_addr};

    engine_slot #(.PAYW(AES_PAYW)) u_aes (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (aes_cmd),
        .cmd_payload (aes_cmd_pay),
        .done        (aes_done),
        .start       (aes_start),
        .busy        (aes_busy),
        .ready       (aes_ready_out),
        .payload     (aes_pay),
        .done_run    (aes_done_run),
        .drop        (aes_drop)
    );

    engine_slot #(.PAYW(SHA_PAYW)) u_sha (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (sha_cmd),
        .cmd_payload (sha_cmd_pay),
        .done        (sha_done),
        .start       (sha_start),
        .busy        (sha_busy),
        .ready       (sha_ready_out),
        .payload     (sha_pay),
        .done_run    (sha_done_run),
        .drop        (sha_drop)
    );

    assign {aes_decrypt, aes_key_addr, aes_text_addr, aes_dest_addr} = aes_pay;
    assign {sha_text_addr, sha_dest_addr} = sha_pay;

    // An owner keeps the bus while requesting; contention is settled by prio_sha,
    // which flips toward the other side every time a fresh grant is issued.
    always_comb begin
        aes_gnt_next = 1'b0;
        sha_gnt_next = 1'b0;
        if (aes_bus_gnt && aes_bus_req) begin
            aes_gnt_next = 1'b1;
        end else if (sha_bus_gnt && sha_bus_req) begin
            sha_gnt_next = 1'b1;
        end else if (aes_bus_req && sha_bus_req) begin
            if (prio_sha) begin
                sha_gnt_next = 1'b1;
            end else begin
                aes_gnt_next = 1'b1;
            end
        end else if (aes_bus_req) begin
            aes_gnt_next = 1'b1;
        end else if (sha_bus_req) begin
            sha_gnt_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aes_bus_gnt  <= 1'b0;
            sha_bus_gnt  <= 1'b0;
            prio_sha     <= 1'b0;
            cmd_overflow <= 1'b0;
        end else begin
            aes_bus_gnt <= aes_gnt_next;
            sha_bus_gnt <= sha_gnt_next;
            if (aes_gnt_next && !aes_bus_gnt) begin
                prio_sha <= 1'b1;
            end else if (sha_gnt_next && !sha_bus_gnt) begin
                prio_sha <= 1'b0;
            end
            if (aes_drop || sha_drop) begin
                cmd_overflow <= 1'b1;
            end
        end
    end

`ifdef CMD_SCHED_STATS_EN
    logic [STAT_W-1:0] aes_cnt_q, sha_cnt_q, drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            aes_cnt_q  <= '0;
            sha_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (aes_done_run) begin
                aes_cnt_q <= sat_inc(aes_cnt_q);
            end
            if (sha_done_run) begin
                sha_cnt_q <= sat_inc(sha_cnt_q);
            end
            if (cmd_discard || aes_drop || sha_drop) begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
            end
        end
    end

    assign stat_aes_cnt  = aes_cnt_q;
    assign stat_sha_cnt  = sha_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
`else
    logic unused_stat_events;

    assign unused_stat_events = ^{aes_done_run, sha_done_run, cmd_discard};
    assign stat_aes_cnt       = '0;
    assign stat_sha_cnt       = '0;
    assign stat_drop_cnt      = '0;
`endif

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed vector bench for cmd_scheduler: a cycle-by-cycle table plus a
// mid-operation reset sequence. Stat expectations collapse to zero unless CMD_SCHED_STATS_EN.
module tb_cmd_scheduler;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_pulse, cmd_en;
    logic [1:0]    cmd_opcode;
    logic [AW-1:0] cmd_key_addr, cmd_text_addr, cmd_dest_addr;
    logic          aes_ready_out, sha_ready_out;
    logic          aes_start, aes_decrypt;
    logic [AW-1:0] aes_key_addr, aes_text_addr, aes_dest_addr;
    logic          aes_done;
    logic          sha_start;
    logic [AW-1:0] sha_text_addr, sha_dest_addr;
    logic          sha_done;
    logic          aes_bus_req, sha_bus_req, aes_bus_gnt, sha_bus_gnt;
    logic          aes_busy, sha_busy, cmd_overflow;
    logic [15:0]   stat_aes_cnt, stat_sha_cnt, stat_drop_cnt;

    int checks = 0;
    int errors = 0;

    cmd_scheduler #(.ADDRW(AW), .OPCODEW(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_pulse     (cmd_pulse),
        .cmd_en        (cmd_en),
        .cmd_opcode    (cmd_opcode),
        .cmd_key_addr  (cmd_key_addr),
        .cmd_text_addr (cmd_text_addr),
        .cmd_dest_addr (cmd_dest_addr),
        .aes_ready_out (aes_ready_out),
        .sha_ready_out (sha_ready_out),
        .aes_start     (aes_start),
        .aes_decrypt   (aes_decrypt),
        .aes_key_addr  (aes_key_addr),
        .aes_text_addr (aes_text_addr),
        .aes_dest_addr (aes_dest_addr),
        .aes_done      (aes_done),
        .sha_start     (sha_start),
        .sha_text_addr (sha_text_addr),
        .sha_dest_addr (sha_dest_addr),
        .sha_done      (sha_done),
        .aes_bus_req   (aes_bus_req),
        .sha_bus_req   (sha_bus_req),
        .aes_bus_gnt   (aes_bus_gnt),
        .sha_bus_gnt   (sha_bus_gnt),
        .aes_busy      (aes_busy),
        .sha_busy      (sha_busy),
        .cmd_overflow  (cmd_overflow),
        .stat_aes_cnt  (stat_aes_cnt),
        .stat_sha_cnt  (stat_sha_cnt),
        .stat_drop_cnt (stat_drop_cnt)
    );

    always #5 clk = ~clk;

    // flags = {aes_start, sha_start, aes_busy, sha_busy, aes_rdy, sha_rdy, aes_gnt, sha_gnt, ovf, decrypt}
    typedef struct {
        logic          pulse;
        logic          en;
        logic [1:0]    op;
        logic [AW-1:0] key, text, dest;
        logic [1:0]    dones;
        logic [1:0]    reqs;
        logic [9:0]    flags;
        logic [AW-1:0] e_aes_key, e_aes_text, e_aes_dest, e_sha_text, e_sha_dest;
        logic [15:0]   e_aes_cnt, e_sha_cnt, e_drop_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkIn(input logic pulse, input logic en, input logic [1:0] op,
                                  input logic [AW-1:0] key, input logic [AW-1:0] text,
                                  input logic [AW-1:0] dest, input logic [1:0] dones,
                                  input logic [1:0] reqs);
        vec_t v;
        v.pulse = pulse; v.en = en; v.op = op;
        v.key = key; v.text = text; v.dest = dest;
        v.dones = dones; v.reqs = reqs;
        v.flags = '0;
        v.e_aes_key = '0; v.e_aes_text = '0; v.e_aes_dest = '0;
        v.e_sha_text = '0; v.e_sha_dest = '0;
        v.e_aes_cnt = '0; v.e_sha_cnt = '0; v.e_drop_cnt = '0;
        return v;
    endfunction

    function automatic vec_t withExp(input vec_t vi, input logic [9:0] flags,
                                     input logic [AW-1:0] ak, input logic [AW-1:0] at,
                                     input logic [AW-1:0] ad, input logic [AW-1:0] st,
                                     input logic [AW-1:0] sd, input logic [15:0] ac,
                                     input logic [15:0] sc, input logic [15:0] dc);
        vec_t v = vi;
        v.flags = flags;
        v.e_aes_key = ak; v.e_aes_text = at; v.e_aes_dest = ad;
        v.e_sha_text = st; v.e_sha_dest = sd;
        v.e_aes_cnt = ac; v.e_sha_cnt = sc; v.e_drop_cnt = dc;
        return v;
    endfunction

    function automatic logic [15:0] statExp(input logic [15:0] v);
`ifdef CMD_SCHED_STATS_EN
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        cmd_pulse     = v.pulse;
        cmd_en        = v.en;
        cmd_opcode    = v.op;
        cmd_key_addr  = v.key;
        cmd_text_addr = v.text;
        cmd_dest_addr = v.dest;
        aes_done      = v.dones[1];
        sha_done      = v.dones[0];
        aes_bus_req   = v.reqs[1];
        sha_bus_req   = v.reqs[0];
        @(posedge clk);
        #1;
    endtask

    task automatic checkVec(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        checkOutput({p, ".aes_start"}, 32'(aes_start), 32'(v.flags[9]));
        checkOutput({p, ".sha_start"}, 32'(sha_start), 32'(v.flags[8]));
        checkOutput({p, ".aes_busy"}, 32'(aes_busy), 32'(v.flags[7]));
        checkOutput({p, ".sha_busy"}, 32'(sha_busy), 32'(v.flags[6]));
        checkOutput({p, ".aes_ready"}, 32'(aes_ready_out), 32'(v.flags[5]));
        checkOutput({p, ".sha_ready"}, 32'(sha_ready_out), 32'(v.flags[4]));
        checkOutput({p, ".aes_gnt"}, 32'(aes_bus_gnt), 32'(v.flags[3]));
        checkOutput({p, ".sha_gnt"}, 32'(sha_bus_gnt), 32'(v.flags[2]));
        checkOutput({p, ".overflow"}, 32'(cmd_overflow), 32'(v.flags[1]));
        checkOutput({p, ".decrypt"}, 32'(aes_decrypt), 32'(v.flags[0]));
        checkOutput({p, ".aes_key"}, 32'(aes_key_addr), 32'(v.e_aes_key));
        checkOutput({p, ".aes_text"}, 32'(aes_text_addr), 32'(v.e_aes_text));
        checkOutput({p, ".aes_dest"}, 32'(aes_dest_addr), 32'(v.e_aes_dest));
        checkOutput({p, ".sha_text"}, 32'(sha_text_addr), 32'(v.e_sha_text));
        checkOutput({p, ".sha_dest"}, 32'(sha_dest_addr), 32'(v.e_sha_dest));
        checkOutput({p, ".aes_cnt"}, 32'(stat_aes_cnt), 32'(statExp(v.e_aes_cnt)));
        checkOutput({p, ".sha_cnt"}, 32'(stat_sha_cnt), 32'(statExp(v.e_sha_cnt)));
        checkOutput({p, ".drop_cnt"}, 32'(stat_drop_cnt), 32'(statExp(v.e_drop_cnt)));
        checkOutput({p, ".one_gnt"}, 32'(aes_bus_gnt & sha_bus_gnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t idle;
        idle = mkIn(1'b0, 1'b0, 2'b00, '0, '0, '0, 2'b00, 2'b00);

        // Dispatch, slot fill, drops, done hand-offs, then arbitration.
        vecs.push_back(withExp(idle, 10'b0000110000, '0, '0, '0, '0, '0, 0, 0, 0));
        vecs.push_back(withExp(mkIn(1, 1, 2'b10, 24'h000100, 24'h000200, 24'h000300, 2'b00, 2'b00),
                       10'b1010110001, 24'h000100, 24'h000200, 24'h000300, '0, '0, 0, 0, 0));
        vecs.push_back(withExp(idle, 10'b0010110001, 24'h000100, 24'h000200, 24'h000300, '0, '0, 0, 0, 0));
        vecs.push_back(withExp(mkIn(1, 0, 2'b10, 24'hDEAD01, 24'hDEAD02, 24'hDEAD03, 2'b00, 2'b00),
                       10'b0010110001, 24'h000100, 24'h000200, 24'h000300, '0, '0, 0, 0, 1));
        vecs.push_back(withExp(mkIn(1, 1, 2'b01, '0, 24'h0000A0, 24'h0000B0, 2'b00, 2'b00),
                       10'b0111110001, 24'h000100, 24'h000200, 24'h000300, 24'h0000A0, 24'h0000B0, 0, 0, 1));
        vecs.push_back(withExp(mkIn(1, 1, 2'b01, '0, 24'h0000A1, 24'h0000B1, 2'b00, 2'b00),
                       10'b0011100001, 24'h000100, 24'h000200, 24'h000300, 24'h0000A0, 24'h0000B0, 0, 0, 1));
        vecs.push_back(withExp(mkIn(1, 1, 2'b01, '0, 24'h0000A2, 24'h0000B2, 2'b00, 2'b00),
                       10'b0011100011, 24'h000100, 24'h000200, 24'h000300, 24'h0000A0, 24'h0000B0, 0, 0, 2));
        vecs.push_back(withExp(mkIn(0, 0, 2'b00, '0, '0, '0, 2'b01, 2'b00),
                       10'b0111110011, 24'h000100, 24'h000200, 24'h000300, 24'h0000A1, 24'h0000B1, 0, 1, 2));
        vecs.push_back(withExp(mkIn(1, 1, 2'b00, 24'h000111, 24'h000222, 24'h000333, 2'b00, 2'b00),
                       10'b0011010011, 24'h000100, 24'h000200, 24'h000300, 24'h0000A1, 24'h0000B1, 0, 1, 2));
        vecs.push_back(withExp(mkIn(1, 1, 2'b00, 24'h000444, 24'h000555, 24'h000666, 2'b10, 2'b00),
                       10'b1011110010, 24'h000111, 24'h000222, 24'h000333, 24'h0000A1, 24'h0000B1, 1, 1, 3));
        vecs.push_back(withExp(mkIn(1, 1, 2'b10, 24'h000555, 24'h000666, 24'h000777, 2'b10, 2'b00),
                       10'b1011110011, 24'h000555, 24'h000666, 24'h000777, 24'h0000A1, 24'h0000B1, 2, 1, 3));
        vecs.push_back(withExp(mkIn(0, 0, 2'b00, '0, '0, '0, 2'b11, 2'b00),
                       10'b0000110011, 24'h000555, 24'h000666, 24'h000777, 24'h0000A1, 24'h0000B1, 3, 2, 3));
        vecs.push_back(withExp(mkIn(0, 0, 2'b00, '0, '0, '0, 2'b11, 2'b00),
                       10'b0000110011, 24'h000555, 24'h000666, 24'h000777, 24'h0000A1, 24'h0000B1, 3, 2, 3));
        vecs.push_back(withExp(mkIn(0, 0, 2'b00, '0, '0, '0, 2'b00, 2'b11),
                       10'b0000111011, 24'h000555, 24'h000666, 24'h000777, 24'h0000A1, 24'h0000B1, 3, 2, 3));
        vecs.push_back(withExp(mkIn(0, 0, 2'b00, '0, '0, '0, 2'b00, 2'b11),
                       10'b0000111011, 24'h000555, 24'h000666, 24'h000777, 24'h0000A1, 24'h0000B1, 3, 2, 3));
        vecs.push_back(withExp(mkIn(0, 0, 2'b00, '0, '0, '0, 2'b00, 2'b01),
                       10'b0000110111, 24'h000555, 24'h000666, 24'h000777, 24'h0000A1, 24'h0000B1, 3, 2, 3));
        vecs.push_back(withExp(mkIn(0, 0, 2'b00, '0, '0, '0, 2'b00, 2'b11),
                       10'b0000110111, 24'h000555, 24'h000666, 24'h000777, 24'h0000A1, 24'h0000B1, 3, 2, 3));
        vecs.push_back(withExp(mkIn(0, 0, 2'b00, '0, '0, '0, 2'b00, 2'b10),
                       10'b0000111011, 24'h000555, 24'h000666, 24'h000777, 24'h0000A1, 24'h0000B1, 3, 2, 3));
        vecs.push_back(withExp(idle, 10'b0000110011, 24'h000555, 24'h000666, 24'h000777, 24'h0000A1, 24'h0000B1, 3, 2, 3));
        vecs.push_back(withExp(mkIn(0, 0, 2'b00, '0, '0, '0, 2'b00, 2'b11),
                       10'b0000110111, 24'h000555, 24'h000666, 24'h000777, 24'h0000A1, 24'h0000B1, 3, 2, 3));
        vecs.push_back(withExp(idle, 10'b0000110011, 24'h000555, 24'h000666, 24'h000777, 24'h0000A1, 24'h0000B1, 3, 2, 3));

        rst = 1'b1;
        cmd_pulse = 1'b0; cmd_en = 1'b0; cmd_opcode = '0;
        cmd_key_addr = '0; cmd_text_addr = '0; cmd_dest_addr = '0;
        aes_done = 1'b0; sha_done = 1'b0; aes_bus_req = 1'b0; sha_bus_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.aes_ready", 32'(aes_ready_out), 32'd1);
        checkOutput("rst.sha_ready", 32'(sha_ready_out), 32'd1);
        checkOutput("rst.busy", 32'({aes_busy, sha_busy}), 32'd0);
        checkOutput("rst.start", 32'({aes_start, sha_start}), 32'd0);
        checkOutput("rst.overflow", 32'(cmd_overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkVec(i, vecs[i]);
        end

        // Load both engines and both slots, then reset mid-operation.
        applyStimulus(mkIn(1, 1, 2'b10, 24'h0A0001, 24'h0A0002, 24'h0A0003, 2'b00, 2'b00));
        applyStimulus(mkIn(1, 1, 2'b00, 24'h0B0001, 24'h0B0002, 24'h0B0003, 2'b00, 2'b00));
        applyStimulus(mkIn(1, 1, 2'b01, '0, 24'h0C0002, 24'h0C0003, 2'b00, 2'b00));
        applyStimulus(mkIn(1, 1, 2'b01, '0, 24'h0D0002, 24'h0D0003, 2'b00, 2'b11));
        checkOutput("pre_rst.busy", 32'({aes_busy, sha_busy}), 32'h3);
        checkOutput("pre_rst.ready", 32'({aes_ready_out, sha_ready_out}), 32'h0);
        checkOutput("pre_rst.aes_gnt", 32'(aes_bus_gnt), 32'd1);

        @(negedge clk);
        rst = 1'b1;
        cmd_pulse = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_rst.busy", 32'({aes_busy, sha_busy}), 32'h0);
        checkOutput("mid_rst.ready", 32'({aes_ready_out, sha_ready_out}), 32'h3);
        checkOutput("mid_rst.gnt", 32'({aes_bus_gnt, sha_bus_gnt}), 32'h0);
        checkOutput("mid_rst.start", 32'({aes_start, sha_start}), 32'h0);
        checkOutput("mid_rst.overflow", 32'(cmd_overflow), 32'd0);
        checkOutput("mid_rst.aes_key", 32'(aes_key_addr), 32'd0);
        checkOutput("mid_rst.sha_text", 32'(sha_text_addr), 32'd0);
        checkOutput("mid_rst.cnts", 32'({stat_aes_cnt, stat_sha_cnt}), 32'd0);
        checkOutput("mid_rst.drop_cnt", 32'(stat_drop_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        aes_bus_req = 1'b0;
        sha_bus_req = 1'b0;

        applyStimulus(mkIn(0, 0, 2'b00, '0, '0, '0, 2'b11, 2'b00));
        checkOutput("post_rst.busy", 32'({aes_busy, sha_busy}), 32'h0);
        checkOutput("post_rst.start", 32'({aes_start, sha_start}), 32'h0);
        checkOutput("post_rst.ready", 32'({aes_ready_out, sha_ready_out}), 32'h3);
        checkOutput("post_rst.cnts", 32'({stat_aes_cnt, stat_sha_cnt}), 32'd0);
        applyStimulus(idle);
        checkOutput("post_rst.gnt", 32'({aes_bus_gnt, sha_bus_gnt}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
